// File: rtl/banked_data_memory.sv
// rtl/banked_data_memory.sv - LANES-wide byte-banked data memory with rotating, extending load/store port
module banked_data_memory #(
  parameter int LANES            = 4,
  parameter int DEPTH_WORDS      = 1024,
  parameter int ALLOW_MISALIGNED = 1,
  parameter int SZW              = $clog2($clog2(LANES) + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [SZW-1:0]       req_size,
  input  logic                 req_write,
  input  logic                 req_signed,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [8*LANES-1:0]   resp_data,
  output logic                 resp_fault
);
  localparam int W    = 8 * LANES;
  localparam int OFFW = $clog2(LANES);
  localparam int AW   = $clog2(DEPTH_WORDS);

  logic            accept;
  logic [OFFW-1:0] offset;
  logic [AW-1:0]   base_w;
  logic [OFFW:0]   nbytes;
  logic            size_bad, range_bad, align_bad, fault;
  logic [W-1:0]    rd_all;

  assign req_ready = !resp_valid || resp_ready;
  assign accept    = req_valid && req_ready;
  assign offset    = req_addr[OFFW-1:0];
  assign base_w    = req_addr[OFFW +: AW];
  assign nbytes    = (OFFW+1)'(1) << req_size;
  assign size_bad  = int'(req_size) > OFFW;
  assign range_bad = |req_addr[31:OFFW+AW];
  // nbytes == LANES truncates to zero here, so the mask becomes all-ones as needed
  assign align_bad = (ALLOW_MISALIGNED == 0) &&
                     ((offset & (nbytes[OFFW-1:0] - OFFW'(1))) != '0);
  assign fault     = size_bad || range_bad || align_bad;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0]      bank [DEPTH_WORDS];
    logic [7:0]      rd;
    logic [OFFW-1:0] k;
    logic [AW-1:0]   addr;
    logic            en;

    // k is the request byte carried by this lane; lanes below the offset wrap into the next word
    assign k    = OFFW'(i) - offset;
    assign en   = accept && !fault && ({1'b0, k} < nbytes);
    assign addr = (OFFW'(i) < offset) ? base_w + AW'(1) : base_w;

    always_ff @(posedge clk) begin
      if (en) begin
        if (req_write) begin
          bank[addr] <= req_wdata[8*k +: 8];
        end
        rd <= bank[addr];
      end
    end

    assign rd_all[8*i +: 8] = rd;
  end

  logic [OFFW-1:0] cap_offset;
  logic [OFFW:0]   cap_nbytes;
  logic            cap_signed, cap_write, cap_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      cap_offset <= '0;
      cap_nbytes <= '0;
      cap_signed <= 1'b0;
      cap_write  <= 1'b0;
      cap_fault  <= 1'b0;
    end else if (req_ready) begin
      resp_valid <= req_valid;
      if (req_valid) begin
        cap_offset <= offset;
        cap_nbytes <= nbytes;
        cap_signed <= req_signed;
        cap_write  <= req_write;
        cap_fault  <= fault;
      end
    end
  end

  // Bank outputs only move on accept, so the rotated result is stable across a stall
  logic [W-1:0]    rot, ext;
  logic [OFFW-1:0] lane;
  logic            sign;

  always_comb begin
    rot  = '0;
    ext  = '0;
    lane = '0;
    sign = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane = cap_offset + OFFW'(k);
      rot[8*k +: 8] = rd_all[8*lane +: 8];
    end
    for (int k = 0; k < LANES; k++) begin
      if ((OFFW+1)'(k + 1) == cap_nbytes) sign = rot[8*k+7];
    end
    for (int k = 0; k < LANES; k++) begin
      ext[8*k +: 8] = ((OFFW+1)'(k) < cap_nbytes) ? rot[8*k +: 8] : {8{cap_signed & sign}};
    end
  end

  assign resp_data  = (resp_valid && !cap_write && !cap_fault) ? ext : '0;
  assign resp_fault = resp_valid && cap_fault;

endmodule

// File: tb/tb_banked_data_memory.sv
// tb/tb_banked_data_memory.sv - bench for banked_data_memory, misaligned-allowed and misaligned-faulting instances
module tb_banked_data_memory;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_signed, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready1, resp_valid1, resp_fault1;
  logic        req_ready0, resp_valid0, resp_fault0;
  logic [31:0] resp_data1, resp_data0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  mem_m [2][4096];

  banked_data_memory #(.LANES(4), .DEPTH_WORDS(1024), .ALLOW_MISALIGNED(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_addr(req_addr), .req_size(req_size), .req_write(req_write), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_ready(resp_ready),
    .resp_data(resp_data1), .resp_fault(resp_fault1));

  banked_data_memory #(.LANES(4), .DEPTH_WORDS(1024), .ALLOW_MISALIGNED(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_addr(req_addr), .req_size(req_size), .req_write(req_write), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
    .resp_data(resp_data0), .resp_fault(resp_fault0));

  always #5 clk = ~clk;

  // Byte-addressed view: an access touches bytes addr..addr+n-1 modulo the memory size
  task automatic model(input int allow, input logic [31:0] addr, input logic [1:0] size,
                       input logic w, input logic s, input logic [31:0] wd,
                       output logic [31:0] data, output logic fault);
    int n;
    n = 1 << size;
    data = '0;
    fault = (size == 2'd3) || (addr >= 32'd4096) || (allow == 0 && (addr % n) != 0);
    if (!fault) begin
      for (int k = 0; k < n; k++) begin
        if (w) mem_m[allow][(addr + k) % 4096] = wd[8*k +: 8];
        else   data[8*k +: 8] = mem_m[allow][(addr + k) % 4096];
      end
      if (!w && s && data[8*n-1] === 1'b1)
        for (int k = n; k < 4; k++) data[8*k +: 8] = 8'hFF;
    end
  endtask

  task automatic xact(input logic [31:0] addr, input logic [1:0] size, input logic w,
                      input logic s, input logic [31:0] wd,
                      output logic [31:0] a1, output logic af1, output logic [31:0] a0, output logic af0,
                      output logic [31:0] e1, output logic ef1, output logic [31:0] e0, output logic ef0,
                      output logic v_ok);
    req_addr = addr; req_size = size; req_write = w; req_signed = s; req_wdata = wd;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    model(1, addr, size, w, s, wd, e1, ef1);
    model(0, addr, size, w, s, wd, e0, ef0);
    v_ok = resp_valid1 && resp_valid0;
    a1 = resp_data1; af1 = resp_fault1; a0 = resp_data0; af0 = resp_fault0;
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_signed = 1'b0;
    req_addr = '0; req_size = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (resp_valid1 !== 1'b0 || resp_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b/%b want 0", resp_valid1, resp_valid0); end
    checks++; if (resp_fault1 !== 1'b0 || resp_fault0 !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b/%b want 0", resp_fault1, resp_fault0); end
    checks++; if (resp_data1 !== 32'h0 || resp_data0 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h want 0", resp_data1, resp_data0); end
    checks++; if (req_ready1 !== 1'b1 || req_ready0 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b/%b want 1", req_ready1, req_ready0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic init_memory();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    for (int w = 0; w < 68; w++) xact(32'(w * 4), 2'd2, 1'b1, 1'b0, $urandom, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    for (int w = 1020; w < 1024; w++) xact(32'(w * 4), 2'd2, 1'b1, 1'b0, $urandom, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
  endtask

  task automatic test_aligned();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    xact(32'h100, 2'd2, 1'b1, 1'b0, 32'hDEADBEEF, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL aligned_store_latency: resp_valid %b want 1", v); end
    checks++; if (a1 !== 32'h0 || af1 !== 1'b0 || a0 !== 32'h0 || af0 !== 1'b0) begin errors++; $display("FAIL aligned_store_resp: got %h/%b %h/%b want 0/0", a1, af1, a0, af0); end
    xact(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL aligned_load_latency: resp_valid %b want 1", v); end
    checks++; if (a1 !== 32'hDEADBEEF || a0 !== 32'hDEADBEEF || af1 !== 1'b0 || af0 !== 1'b0) begin errors++; $display("FAIL aligned_load: got %h/%h want deadbeef", a1, a0); end
  endtask

  task automatic test_misaligned();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    xact(32'h103, 2'd2, 1'b1, 1'b0, 32'h11223344, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (af1 !== 1'b0 || af0 !== 1'b1) begin errors++; $display("FAIL mis_store_fault: got %b/%b want 0/1", af1, af0); end
    xact(32'h103, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'h11223344) begin errors++; $display("FAIL mis_load_word: got %h want 11223344", a1); end
    checks++; if (af0 !== 1'b1 || a0 !== 32'h0) begin errors++; $display("FAIL mis_load_strict: got %h/%b want 0/1", a0, af0); end
    xact(32'h104, 2'd0, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'h33) begin errors++; $display("FAIL mis_load_byte: got %h want 00000033", a1); end
    checks++; if (a0 !== e0 || af0 !== 1'b0) begin errors++; $display("FAIL mis_strict_untouched: got %h want %h", a0, e0); end
  endtask

  task automatic test_extension();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    xact(32'h20, 2'd0, 1'b1, 1'b0, 32'hABCDEF80, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    xact(32'h20, 2'd0, 1'b0, 1'b1, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'hFFFFFF80 || a0 !== 32'hFFFFFF80) begin errors++; $display("FAIL ext_byte_signed: got %h/%h want ffffff80", a1, a0); end
    xact(32'h20, 2'd0, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'h80 || a0 !== 32'h80) begin errors++; $display("FAIL ext_byte_unsigned: got %h/%h want 00000080", a1, a0); end
    xact(32'h22, 2'd1, 1'b1, 1'b0, 32'h12348001, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    xact(32'h22, 2'd1, 1'b0, 1'b1, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'hFFFF8001 || a0 !== 32'hFFFF8001) begin errors++; $display("FAIL ext_half_signed: got %h/%h want ffff8001", a1, a0); end
    xact(32'h20, 2'd2, 1'b0, 1'b1, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== e1 || a0 !== e0) begin errors++; $display("FAIL ext_word_merge: got %h/%h want %h/%h", a1, a0, e1, e0); end
  endtask

  task automatic test_faults();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    xact(32'h102, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (af0 !== 1'b1 || a0 !== 32'h0) begin errors++; $display("FAIL fault_misaligned: got %h/%b want 0/1", a0, af0); end
    checks++; if (af1 !== 1'b0 || a1 !== e1) begin errors++; $display("FAIL allowed_misaligned: got %h/%b want %h/0", a1, af1, e1); end
    xact(32'h1000, 2'd2, 1'b1, 1'b0, 32'h5A5A5A5A, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (af1 !== 1'b1 || af0 !== 1'b1 || a1 !== 32'h0) begin errors++; $display("FAIL fault_range: got %b/%b data %h want 1/1 0", af1, af0, a1); end
    xact(32'h0, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== e1 || a0 !== e0) begin errors++; $display("FAIL fault_range_no_write: got %h/%h want %h/%h", a1, a0, e1, e0); end
    xact(32'h0, 2'd3, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (af1 !== 1'b1 || a1 !== 32'h0) begin errors++; $display("FAIL fault_size: got %h/%b want 0/1", a1, af1); end
    xact(32'h102, 2'd2, 1'b1, 1'b0, 32'hC0FFEE00, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    xact(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a0 !== e0 || a1 !== e1) begin errors++; $display("FAIL fault_mis_no_write: got %h/%h want %h/%h", a1, a0, e1, e0); end
  endtask

  task automatic test_wrap();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    xact(32'hFFE, 2'd2, 1'b1, 1'b0, 32'hAABBCCDD, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (af1 !== 1'b0) begin errors++; $display("FAIL wrap_store_fault: got %b want 0", af1); end
    xact(32'h0, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1[15:0] !== 16'hAABB || a1 !== e1) begin errors++; $display("FAIL wrap_word0: got %h want %h", a1, e1); end
    xact(32'hFFE, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== 32'hAABBCCDD || af0 !== 1'b1) begin errors++; $display("FAIL wrap_load: got %h/%b want aabbccdd/1", a1, af0); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    req_addr = 32'h100; req_size = 2'd2; req_write = 1'b0; req_signed = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    model(1, 32'h100, 2'd2, 1'b0, 1'b0, 32'h0, e1, ef1);
    model(0, 32'h100, 2'd2, 1'b0, 1'b0, 32'h0, e0, ef0);
    req_write = 1'b1; req_wdata = 32'h0BADF00D;
    for (int i = 0; i < 5; i++) begin
      checks++; if (resp_valid1 !== 1'b1 || req_ready1 !== 1'b0 || req_ready0 !== 1'b0) begin errors++; $display("FAIL stall_ctrl[%0d]: valid %b ready %b/%b want 1 0/0", i, resp_valid1, req_ready1, req_ready0); end
      checks++; if (resp_data1 !== e1 || resp_data0 !== e0) begin errors++; $display("FAIL stall_data[%0d]: got %h/%h want %h/%h", i, resp_data1, resp_data0, e1, e0); end
      @(posedge clk); #1;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (resp_valid1 !== 1'b0 || resp_valid0 !== 1'b0) begin errors++; $display("FAIL stall_release: valid %b/%b want 0", resp_valid1, resp_valid0); end
    xact(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== e1 || a0 !== e0) begin errors++; $display("FAIL stall_no_write: got %h/%h want %h/%h", a1, a0, e1, e0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a1, a0, e1, e0; logic af1, af0, ef1, ef0, v;
    req_addr = 32'h20; req_size = 2'd2; req_write = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid1 !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: valid %b want 1", resp_valid1); end
    rst_n = 1'b0; #1;
    checks++; if (resp_valid1 !== 1'b0 || resp_valid0 !== 1'b0 || resp_data1 !== 32'h0) begin errors++; $display("FAIL rst_mid_async: valid %b/%b data %h want 0", resp_valid1, resp_valid0, resp_data1); end
    @(posedge clk); #1;
    rst_n = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    xact(32'h100, 2'd2, 1'b0, 1'b0, 32'h0, a1, af1, a0, af0, e1, ef1, e0, ef0, v);
    checks++; if (a1 !== e1 || a0 !== e0) begin errors++; $display("FAIL rst_keeps_mem: got %h/%h want %h/%h", a1, a0, e1, e0); end
  endtask

  task automatic test_stream(input int n, input int valid_pct, input int ready_pct);
    logic [31:0] qd1[$], qd0[$];
    logic        qf1[$], qf0[$];
    int          sent, cyc, r;
    logic [31:0] a, wd, d1, d0;
    logic [1:0]  sz;
    logic        w, s, f1, f0, acc, exp_valid, exp_ready;
    sent = 0; cyc = 0;
    while ((sent < n || qd1.size() > 0) && cyc < 20000) begin
      cyc++;
      r = int'($urandom_range(0, 99));
      if (r < 65)      a = $urandom_range(0, 32'h10C);
      else if (r < 85) a = $urandom_range(32'hFF0, 32'hFFF);
      else             a = $urandom | 32'h1000;
      sz = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1)); s = 1'($urandom_range(0, 1)); wd = $urandom;
      req_addr = a; req_size = sz; req_write = w; req_signed = s; req_wdata = wd;
      req_valid = (sent < n) && ($urandom_range(0, 99) < valid_pct);
      resp_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      exp_valid = qd1.size() > 0;
      exp_ready = !exp_valid || resp_ready;
      checks++; if (resp_valid1 !== exp_valid || resp_valid0 !== exp_valid) begin errors++; $display("FAIL stream_valid@%0d: got %b/%b want %b", cyc, resp_valid1, resp_valid0, exp_valid); end
      checks++; if (req_ready1 !== exp_ready || req_ready0 !== exp_ready) begin errors++; $display("FAIL stream_ready@%0d: got %b/%b want %b", cyc, req_ready1, req_ready0, exp_ready); end
      if (exp_valid) begin
        checks++; if (resp_data1 !== qd1[0] || resp_fault1 !== qf1[0]) begin errors++; $display("FAIL stream_resp1@%0d: got %h/%b want %h/%b", cyc, resp_data1, resp_fault1, qd1[0], qf1[0]); end
        checks++; if (resp_data0 !== qd0[0] || resp_fault0 !== qf0[0]) begin errors++; $display("FAIL stream_resp0@%0d: got %h/%b want %h/%b", cyc, resp_data0, resp_fault0, qd0[0], qf0[0]); end
        if (resp_ready) begin
          void'(qd1.pop_front()); void'(qf1.pop_front()); void'(qd0.pop_front()); void'(qf0.pop_front());
        end
      end
      acc = req_valid && exp_ready;
      @(posedge clk); #1;
      if (acc) begin
        model(1, a, sz, w, s, wd, d1, f1);
        model(0, a, sz, w, s, wd, d0, f0);
        qd1.push_back(d1); qf1.push_back(f1); qd0.push_back(d0); qf0.push_back(f0);
        sent++;
      end
    end
    checks++; if (sent != n || qd1.size() != 0) begin errors++; $display("FAIL stream_timeout: sent %0d of %0d, %0d outstanding", sent, n, qd1.size()); end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    init_memory();
    test_aligned();
    test_misaligned();
    test_extension();
    test_faults();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    test_stream(300, 100, 100);
    test_stream(400, 70, 60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
